// File: rtl/kpg_pkg.sv
// Shared KPG code constants and the prefix combine operator for the pipelined adder.
package kpg_pkg;

    localparam logic [1:0] KPG_KILL = 2'b00;
    localparam logic [1:0] KPG_PROP = 2'b01;
    localparam logic [1:0] KPG_GEN  = 2'b11;

    // A propagating high group (01, or the alias 10) passes the low group's code through.
    function automatic logic [1:0] kpg_combine(input logic [1:0] hi, input logic [1:0] lo);
        case (hi)
            KPG_KILL: return KPG_KILL;
            KPG_GEN:  return KPG_GEN;
            default:  return lo;
        endcase
    endfunction

endpackage

// File: rtl/kpg_level.sv
// One combinational Kogge-Stone prefix level at a fixed distance over a packed code vector.
module kpg_level
    import kpg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [2*WIDTH-1:0] x,
    output logic [2*WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_comb
            assign y[2*i +: 2] = kpg_combine(x[2*i +: 2], x[2*(i-DIST) +: 2]);
        end else begin : g_pass
            assign y[2*i +: 2] = x[2*i +: 2];
        end
    end

endmodule

// File: rtl/kpg_pipe_adder.sv
// Pipelined KPG prefix adder/subtractor: rank 0 holds generated codes, ranks 1..NLEV one
// prefix level each; a single global advance stalls or moves every rank together.
module kpg_pipe_adder
    import kpg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NLEV = $clog2(WIDTH);

    logic                          adv;
    logic [WIDTH-1:0]              b_eff;
    logic [WIDTH-1:0]              p_in;
    logic                          c0_in;
    logic [2*WIDTH-1:0]            gen_code;

    logic [NLEV:0]                 vld_pipe;
    logic [NLEV:0][2*WIDTH-1:0]    code_q;
    logic [NLEV:0][WIDTH-1:0]      p_q;
    logic [NLEV:0]                 c0_q;
    logic [NLEV-1:0][2*WIDTH-1:0]  lvl_code;

    logic [2*WIDTH-1:0]            last_code;
    logic [WIDTH-1:0]              carry;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Bit 0 absorbs the carry-in here, so no position is left propagating after the last level.
    always_comb begin
        b_eff    = sub ? ~b : b;
        c0_in    = sub ? 1'b1 : cin;
        p_in     = a ^ b_eff;
        gen_code = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i] && b_eff[i])
                gen_code[2*i +: 2] = KPG_GEN;
            else if (p_in[i])
                gen_code[2*i +: 2] = KPG_PROP;
            else
                gen_code[2*i +: 2] = KPG_KILL;
        end
        gen_code[1:0] = ((a[0] & b_eff[0]) | (p_in[0] & c0_in)) ? KPG_GEN : KPG_KILL;
    end

    for (genvar l = 0; l < NLEV; l++) begin : g_lvl
        kpg_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << l)
        ) u_lvl (
            .x (code_q[l]),
            .y (lvl_code[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            code_q   <= '0;
            p_q      <= '0;
            c0_q     <= '0;
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[NLEV-1:0], in_valid};
            code_q[0] <= gen_code;
            p_q[0]    <= p_in;
            c0_q[0]   <= c0_in;
            for (int l = 1; l <= NLEV; l++) begin
                code_q[l] <= lvl_code[l-1];
                p_q[l]    <= p_q[l-1];
                c0_q[l]   <= c0_q[l-1];
            end
        end
    end

    assign last_code = code_q[NLEV];

    always_comb begin
        carry    = '0;
        carry[0] = c0_q[NLEV];
        for (int i = 1; i < WIDTH; i++)
            carry[i] = (last_code[2*(i-1) +: 2] == KPG_GEN);
    end

    assign out_valid = vld_pipe[NLEV];
    assign sum       = p_q[NLEV] ^ carry;
    assign cout      = (last_code[2*WIDTH-1 -: 2] == KPG_GEN);
    assign ovf       = carry[WIDTH-1] ^ cout;
    assign zero      = ~|sum;

endmodule

// File: tb/tb_kpg_pipe_adder.sv
// Scoreboard bench for kpg_pipe_adder at WIDTH 16, 8 and 12.
module tb_kpg_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16, z16;
    logic [15:0] a16, b16, s16;
    logic        iv8, ir8, ov8, or8, cin8, sub8, co8, of8, z8;
    logic [7:0]  a8, b8, s8;
    logic        iv12, ir12, ov12, or12, cin12, sub12, co12, of12, z12;
    logic [11:0] a12, b12, s12;

    kpg_pipe_adder #(.WIDTH(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .cout(co16), .ovf(of16), .zero(z16));

    kpg_pipe_adder #(.WIDTH(8)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .ovf(of8), .zero(z8));

    kpg_pipe_adder #(.WIDTH(12)) u_d12 (
        .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12), .a(a12), .b(b12),
        .cin(cin12), .sub(sub12), .out_valid(ov12), .out_ready(or12), .sum(s12),
        .cout(co12), .ovf(of12), .zero(z12));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q16[$], q8[$], q12[$];
    int   checks = 0, errors = 0, cyc = 0, npop16 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
        exp_t e;
        logic [16:0] mask, be, full;
        mask   = (17'd1 << w) - 17'd1;
        be     = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        full   = ({1'b0, a} & mask) + be + (sub ? 17'd1 : {16'd0, cin});
        e.sum  = full[15:0] & mask[15:0];
        e.cout = full[w];
        e.ovf  = (a[w-1] == be[w-1]) && (e.sum[w-1] != a[w-1]);
        e.zero = (e.sum == 16'd0);
        e.acc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(logic [15:0] s, logic c, logic o, logic z, bit lat);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.acc = 0; e.lat = lat;
        return e;
    endfunction

    // Output monitors: pop one expectation per output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov16 && or16) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL w16_unexpected: got sum=%h with nothing outstanding", s16);
            end else begin
                e = q16.pop_front();
                npop16++;
                if ({s16, co16, of16, z16} !== {e.sum, e.cout, e.ovf, e.zero}) begin
                    errors++;
                    $display("FAIL w16_result: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                             s16, co16, of16, z16, e.sum, e.cout, e.ovf, e.zero);
                end
                if (e.lat) begin
                    checks++;
                    if (cyc - e.acc != 4) begin
                        errors++;
                        $display("FAIL w16_latency: got %0d want 4", cyc - e.acc);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov8 && or8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL w8_unexpected: got sum=%h with nothing outstanding", s8);
            end else begin
                e = q8.pop_front();
                if ({s8, co8, of8, z8} !== {e.sum[7:0], e.cout, e.ovf, e.zero}) begin
                    errors++;
                    $display("FAIL w8_result: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                             s8, co8, of8, z8, e.sum[7:0], e.cout, e.ovf, e.zero);
                end
                if (e.lat) begin
                    checks++;
                    if (cyc - e.acc != 3) begin
                        errors++;
                        $display("FAIL w8_latency: got %0d want 3", cyc - e.acc);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov12 && or12) begin
            checks++;
            if (q12.size() == 0) begin
                errors++;
                $display("FAIL w12_unexpected: got sum=%h with nothing outstanding", s12);
            end else begin
                e = q12.pop_front();
                if ({s12, co12, of12, z12} !== {e.sum[11:0], e.cout, e.ovf, e.zero}) begin
                    errors++;
                    $display("FAIL w12_result: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                             s12, co12, of12, z12, e.sum[11:0], e.cout, e.ovf, e.zero);
                end
                if (e.lat) begin
                    checks++;
                    if (cyc - e.acc != 4) begin
                        errors++;
                        $display("FAIL w12_latency: got %0d want 4", cyc - e.acc);
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the operand.
    // in_valid is left high so consecutive calls stream back to back.
    task automatic push_op(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub, exp_t e);
        bit got = 1'b0;
        logic r;
        case (w)
            16:      begin iv16 = 1'b1; a16 = a;        b16 = b;        cin16 = cin; sub16 = sub; end
            8:       begin iv8  = 1'b1; a8  = a[7:0];   b8  = b[7:0];   cin8  = cin; sub8  = sub; end
            default: begin iv12 = 1'b1; a12 = a[11:0];  b12 = b[11:0];  cin12 = cin; sub12 = sub; end
        endcase
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            r = (w == 16) ? ir16 : (w == 8) ? ir8 : ir12;
            if (r) begin
                e.acc = cyc + 1;
                case (w)
                    16:      q16.push_back(e);
                    8:       q8.push_back(e);
                    default: q12.push_back(e);
                endcase
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL w%0d_accept: got in_ready=0 for 200 cycles want 1", w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(int w);
        int n;
        for (int k = 0; k < 100; k++) begin
            n = (w == 16) ? q16.size() : (w == 8) ? q8.size() : q12.size();
            if (n == 0) break;
            @(posedge clk);
        end
        n = (w == 16) ? q16.size() : (w == 8) ? q8.size() : q12.size();
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL w%0d_drain: got %0d outstanding want 0", w, n);
            q16.delete(); q8.delete(); q12.delete();
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ov16, s16, z16, ir16, co16, of16} !== {1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset16: got v=%b s=%h z=%b rdy=%b c=%b o=%b want v=0 s=0000 z=1 rdy=1 c=0 o=0",
                     ov16, s16, z16, ir16, co16, of16);
        end
        checks++;
        if ({ov8, ov12, z8, z12} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_w8_w12: got v8=%b v12=%b z8=%b z12=%b want 0 0 1 1", ov8, ov12, z8, z12);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ripple();
        push_op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1));
        iv16 = 1'b0;
        wait_drain(16);
        push_op(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1));
        iv16 = 1'b0;
        wait_drain(16);
    endtask

    task automatic test_subtract();
        push_op(16, 16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1));
        push_op(16, 16'h0007, 16'h0005, 1'b0, 1'b1, mk(16'h0002, 1'b1, 1'b0, 1'b0, 1'b1));
        push_op(16, 16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1));
        push_op(16, 16'h0007, 16'h0005, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b0, 1'b0, 1'b1));
        push_op(16, 16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1));
        push_op(16, 16'h0000, 16'h0000, 1'b1, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1));
        iv16 = 1'b0;
        wait_drain(16);
    endtask

    task automatic test_back_to_back();
        int start = npop16;
        logic [18:0] hold;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    push_op(16, 16'(i), 16'h0100, 1'b0, 1'b0,
                            mk(16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0));
                iv16 = 1'b0;
            end
            begin
                for (int k = 0; k < 200; k++) begin
                    @(posedge clk);
                    #1;
                    if (npop16 - start >= 2) break;
                end
                or16 = 1'b0;
                @(negedge clk);
                hold = {s16, co16, of16, z16};
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    checks++;
                    if ({ir16, ov16} !== 2'b01) begin
                        errors++;
                        $display("FAIL stall_ready: got in_ready=%b out_valid=%b want 0 1", ir16, ov16);
                    end
                    checks++;
                    if ({s16, co16, of16, z16} !== hold) begin
                        errors++;
                        $display("FAIL stall_stable: got %h want %h", {s16, co16, of16, z16}, hold);
                    end
                end
                @(posedge clk);
                #1 or16 = 1'b1;
            end
        join
        wait_drain(16);
        checks++;
        if (npop16 - start != 6) begin
            errors++;
            $display("FAIL stream_count: got %0d results want 6", npop16 - start);
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++)
            push_op(16, 16'h1000 + 16'(i), 16'h0011, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        iv16 = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        iv16 = 1'b1;
        a16  = 16'hABCD;
        b16  = 16'h1111;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        iv16 = 1'b0;
        q16.delete();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (ov16 !== 1'b0) begin
                errors++;
                $display("FAIL midflight_valid: got out_valid=%b sum=%h want 0", ov16, s16);
            end
        end
        @(posedge clk);
        #1;
        push_op(16, 16'h1234, 16'h1111, 1'b1, 1'b0, mk(16'h2346, 1'b0, 1'b0, 1'b0, 1'b1));
        iv16 = 1'b0;
        wait_drain(16);
    endtask

    task automatic test_widths();
        push_op(8, 16'h0080, 16'h0080, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1));
        iv8 = 1'b0;
        wait_drain(8);
        push_op(12, 16'h0FFF, 16'h0001, 1'b1, 1'b0, mk(16'h0001, 1'b1, 1'b0, 1'b0, 1'b1));
        iv12 = 1'b0;
        wait_drain(12);
    endtask

    task automatic test_random();
        int ws[3] = '{8, 12, 16};
        bit done = 1'b0;
        fork
            begin
                for (int j = 0; j < 3; j++) begin
                    int w = ws[j];
                    logic [15:0] mask = 16'((32'd1 << w) - 1);
                    for (int n = 0; n < 40; n++) begin
                        logic [15:0] ra = 16'($urandom) & mask;
                        logic [15:0] rb = 16'($urandom) & mask;
                        logic        rc = 1'($urandom);
                        logic        rs = 1'($urandom);
                        push_op(w, ra, rb, rc, rs, model(w, ra, rb, rc, rs));
                    end
                    iv8 = 1'b0; iv12 = 1'b0; iv16 = 1'b0;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    or8  = ($urandom_range(0, 3) != 0);
                    or12 = ($urandom_range(0, 3) != 0);
                    or16 = ($urandom_range(0, 3) != 0);
                end
                or8 = 1'b1; or12 = 1'b1; or16 = 1'b1;
            end
        join
        wait_drain(8);
        wait_drain(12);
        wait_drain(16);
    endtask

    initial begin
        rst  = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
        iv8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0; or8  = 1'b1;
        iv12 = 1'b0; a12 = '0; b12 = '0; cin12 = 1'b0; sub12 = 1'b0; or12 = 1'b1;
        test_reset();
        test_ripple();
        test_subtract();
        test_back_to_back();
        test_reset_midflight();
        test_widths();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion within 500000 time units want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/kpg_pipe_adder.md
# kpg_pipe_adder

Parametrised, pipelined kill/propagate/generate (KPG) prefix adder/subtractor for the ALU datapath. It generalises the fixed 16-bit single-level KPG combine to any `WIDTH`, with one register rank per prefix level, valid/ready flow control, carry-in, a subtract mode and status flags. It sits between operand select and the ALU result mux, and is the final carry-propagate adder behind the Wallace-tree multiplier.

## Interface
- `WIDTH`, 16: operand width. Minimum 2; need not be a power of two.
- `NLEV`, `$clog2(WIDTH)`: derived, not overridden. Number of prefix levels.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  block accepts operands this cycle
- `a`, `b`  in  WIDTH each  operands
- `cin`  in  1  carry-in; ignored when `sub`=1
- `sub`  in  1  1 = a − b
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `sum`  out  WIDTH  result
- `cout`  out  1  carry out; for subtract, 1 = no borrow
- `ovf`  out  1  signed overflow
- `zero`  out  1  `sum` == 0

## Operation
- **Operand preparation:** `b_eff = sub ? ~b : b`, `c0 = sub ? 1 : cin`.
- **Per-bit KPG codes (bit i):**
  - `p_i = a_i ^ b_eff_i`
  - code = 00 (kill) if both bits 0; 11 (generate) if both bits 1; 01 (propagate) otherwise.
  - Code 10 is also accepted as propagate on input to a combine.
- **Carry-in fold:** bit 0 is resolved at generation. Code is 11 if `(a0&b0)|(p0&c0)`, else 00. No bit stays in propagate after level NLEV.
- **Combine `hi∘lo`:** hi = kill → kill; hi = generate → generate; hi = propagate → lo.
- **Prefix levels:** Kogge-Stone. Level L (1..NLEV) uses distance d = 2^(L−1). Position i ≥ d becomes `x[i]∘x[i−d]`; positions i < d pass through.
- **Outputs from the level-NLEV rank:**
  - `carry_i` = (code[i−1] == 11) for i ≥ 1; `carry_0 = c0`
  - `sum_i = p_i ^ carry_i`
  - `cout` = (code[WIDTH−1] == 11)
  - `ovf = carry_{WIDTH−1} ^ cout`
  - `zero = ~|sum`
- `p` and `c0` travel down the pipeline alongside the codes.
- **Flow control:**
  - `adv = !out_valid || out_ready`, and `in_ready = adv`.
  - When `adv`=1, every rank loads from its predecessor. Rank 0 loads from the inputs and its valid bit takes `in_valid`.
  - When `adv`=0, all ranks hold.
  - Bubbles propagate as invalid ranks and are never compacted.
- **Reset:** clears every rank's valid bit and data. After reset: `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, `zero`=1, `in_ready`=1.

## Timing
- There are NLEV+1 register ranks: rank 0 holds the generated codes, and ranks 1..NLEV hold one prefix level each.
- **Latency:** an operand accepted at edge t (`in_valid && in_ready`) appears with `out_valid`=1 immediately after edge t+NLEV. For WIDTH=16 that is edge t+4.
- **Throughput:** one result per cycle while `out_ready`=1.
- `sum`, `cout`, `ovf` and `zero` are combinational from the last rank only. They stay stable while `out_valid && !out_ready`.
- `in_ready` depends combinationally on `out_ready`.
- **Reset mid-flight:** all in-flight operations are discarded. `out_valid`=0 after that edge, even if `out_ready` was high.
- **`rst` and `in_valid` in the same cycle:** reset wins and the operand is dropped.

## Structure
- **Shared package `kpg_pkg`:**
  - constants `KPG_KILL`=2'b00, `KPG_PROP`=2'b01, `KPG_GEN`=2'b11
  - function `kpg_combine(hi, lo)`
- **Sub-module `kpg_level`:**
  - parameters `WIDTH` and `DIST`
  - combinational single prefix level over a 2·WIDTH-bit code vector
  - instantiated NLEV times in a generate loop
  - the parent owns all registers and valid bits.

## Test plan
1. **Reset:** assert `rst` 2 cycles. Require `out_valid`=0, `sum`=0, `zero`=1, `in_ready`=1.
2. **WIDTH=16 carry ripple:** a=0xFFFF, b=0x0001, cin=0. Four edges after acceptance require `sum`=0x0000, `cout`=1, `zero`=1, `ovf`=0. Repeat with a=0x7FFF, b=0x0001: require `sum`=0x8000, `ovf`=1, `cout`=0.
3. **Subtract:**
   - 5−7 → `sum`=0xFFFE, `cout`=0, `ovf`=0
   - 7−5 → `sum`=0x0002, `cout`=1
   - 0x8000−0x0001 → `sum`=0x7FFF, `ovf`=1
   - with `cin`=1 and `sub`=1, `cin` has no effect.
4. **Streaming with backpressure:** feed 6 back-to-back adds (i+0x0100 for i=0..5). Drop `out_ready` for 3 cycles after the second result. Require:
   - `in_ready`=0 during the stall
   - outputs stable through the stall
   - all 6 results in order, with no loss or duplication.
5. **Reset mid-flight:** accept 3 operations, then pulse `rst` at edge t+2. Require `out_valid`=0 until new operands are accepted, and no stale result ever appears.
6. **WIDTH=8 (NLEV=3) and WIDTH=12 (non-power-of-two):**
   - 8-bit: 0x80+0x80 → `sum`=0x00, `cout`=1, `ovf`=1, latency 3.
   - 12-bit: 0xFFF+0x001 with cin=1 → `sum`=0x001, `cout`=1.
   - Randomised comparison of both widths against `a+b_eff+c0`.
